// File: rtl/io_entrada_responder_pkg.sv
// Shared definitions for the IN-instruction responder.
// Holds the CPU data word width and the responder FSM state encoding.
package io_entrada_responder_pkg;

    // Data word width shared with the CPU datapath.
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_RELEASE = 3'd1,
        ST_WAIT_PRESS   = 3'd2,
        ST_CAPTURE      = 3'd3,
        ST_DONE         = 3'd4
    } io_state_e;

endpackage

// File: rtl/io_entrada_responder_debounce_sync.sv
// Synchroniser plus stability-counter debouncer for one board button.
// Ports:
//   clock      in  system clock, posedge
//   reset      in  asynchronous active-low reset
//   raw        in  asynchronous, bouncing button level
//   btn_db     out debounced level (registered)
//   press_evt  out one-cycle pulse on a btn_db rise (registered)
module io_entrada_responder_debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic btn_db,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Metastability chain, bit 0 samples the pin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive cycles of disagreement; the level is accepted on the
    // DEBOUNCE_CYCLES-th one, so the counter never runs past DEBOUNCE_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            btn_db    <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync_lvl == btn_db) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q     <= '0;
                btn_db    <= sync_lvl;
                press_evt <= sync_lvl;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_entrada_responder.sv
// Device-side responder for the CPU IN instruction.
// Debounces the board button, synchronises the switch bank, pauses the CPU
// while a request waits for a fresh press, then returns the zero-extended
// switch value with a one-cycle ready pulse.
// Ports:
//   clock             in  system clock, posedge
//   reset             in  asynchronous active-low reset
//   comandoIN         in  CPU IN request level, held until pronto
//   botaoPlaca        in  raw board button (active-high, bouncing)
//   entradaDeDadosIO  in  raw switch bank
//   dadosLidos        out captured switches, zero-extended to the word width
//   pronto            out one-cycle pulse: request served, dadosLidos valid
//   pausa             out request pending, stalls the PC
//   ledin             out "waiting for input" LED, same as pausa
module io_entrada_responder
    import io_entrada_responder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DATA_W          = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              comandoIN,
    input  logic              botaoPlaca,
    input  logic [DATA_W-1:0] entradaDeDadosIO,
    output logic [WORD_W-1:0] dadosLidos,
    output logic              pronto,
    output logic              pausa,
    output logic              ledin
);

    logic                               btn_db;
    logic                               press_evt;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;
    io_state_e                          state_q;
    io_state_e                          state_d;
    logic                               capture_c;
    logic                               busy_c;

    io_entrada_responder_debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn (
        .clock     (clock),
        .reset     (reset),
        .raw       (botaoPlaca),
        .btn_db    (btn_db),
        .press_evt (press_evt)
    );

    // Switch bank synchroniser; switches are level data, no debounce needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_sync_q <= '0;
        end else begin
            sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], entradaDeDadosIO};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. A request arriving while the button is already down must
    // first see a release, so a stale press is never consumed.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (comandoIN) begin
                    state_d = btn_db ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!comandoIN) begin
                    state_d = ST_IDLE;
                end else if (!btn_db) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (!comandoIN) begin
                    state_d = ST_IDLE;
                end else if (press_evt) begin
                    state_d   = ST_CAPTURE;
                    capture_c = 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!comandoIN) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_c = (state_d == ST_WAIT_RELEASE) || (state_d == ST_WAIT_PRESS);

    // Outputs registered from the next state so they track the state register
    // exactly, with no combinational path from comandoIN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dadosLidos <= '0;
            pronto     <= 1'b0;
            pausa      <= 1'b0;
            ledin      <= 1'b0;
        end else begin
            pronto <= (state_d == ST_CAPTURE);
            pausa  <= busy_c;
            ledin  <= busy_c;
            if (capture_c) begin
                dadosLidos <= WORD_W'(sw_sync_q[SYNC_STAGES-1]);
            end
        end
    end

endmodule

// File: tb/tb_io_entrada_responder.sv
// Self-checking bench for io_entrada_responder: directed scenarios followed
// by a randomised phase, all compared every cycle against a behavioural model.
module tb_io_entrada_responder;

    localparam int unsigned DB = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DW = 4;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          comandoIN  = 1'b0;
    logic          botaoPlaca = 1'b0;
    logic [DW-1:0] sw         = '0;
    logic [31:0]   dadosLidos;
    logic          pronto;
    logic          pausa;
    logic          ledin;

    int n_cmp = 0;
    int n_bad = 0;

    io_entrada_responder #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .DATA_W          (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .comandoIN        (comandoIN),
        .botaoPlaca       (botaoPlaca),
        .entradaDeDadosIO (sw),
        .dadosLidos       (dadosLidos),
        .pronto           (pronto),
        .pausa            (pausa),
        .ledin            (ledin)
    );

    always #5 clock = ~clock;

    // Reference model: request bookkeeping as flags, button as a delay line
    // plus "stable for DB consecutive samples" rule.
    bit          m_busy, m_armed, m_ack, m_done;
    bit          m_db, m_evt;
    int          m_run;
    logic [31:0] m_data;
    bit          btn_pipe[$];
    logic [DW-1:0] sw_pipe[$];

    task automatic model_reset();
        m_busy = 0; m_armed = 0; m_ack = 0; m_done = 0;
        m_db = 0; m_evt = 0; m_run = 0; m_data = '0;
        btn_pipe.delete();
        sw_pipe.delete();
        for (int i = 0; i < int'(SS); i++) begin
            btn_pipe.push_back(1'b0);
            sw_pipe.push_back('0);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("dadosLidos", dadosLidos, m_data);
        check("pronto", 32'(pronto), 32'(m_ack));
        check("pausa", 32'(pausa), 32'(m_busy));
        check("ledin", 32'(ledin), 32'(m_busy));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit            sb;
        logic [DW-1:0] ssw;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            sb  = btn_pipe.pop_front();
            btn_pipe.push_back(botaoPlaca);
            ssw = sw_pipe.pop_front();
            sw_pipe.push_back(sw);
            if (m_ack) begin
                m_ack  = 0;
                m_done = 1;
            end else if (m_done) begin
                if (!comandoIN) m_done = 0;
            end else if (m_busy) begin
                if (!comandoIN) begin
                    m_busy = 0;
                end else if (!m_armed) begin
                    if (!m_db) m_armed = 1;
                end else if (m_evt) begin
                    m_busy = 0;
                    m_ack  = 1;
                    m_data = 32'(ssw);
                end
            end else if (comandoIN) begin
                m_busy  = 1;
                m_armed = !m_db;
            end
            m_evt = 0;
            if (sb != m_db) begin
                m_run++;
                if (m_run == int'(DB)) begin
                    m_db  = sb;
                    m_evt = sb;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Run n cycles, reporting the cycle index of the first pronto and the pronto count.
    task automatic run_window(input int n, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (pronto === 1'b1) begin
                cnt++;
                if (first == 0) begin
                    first = k;
                    check("pausa_at_pronto", 32'(pausa), 32'd0);
                end
            end
        end
    endtask

    initial begin
        int first;
        int cnt;
        int hold;

        model_reset();

        // 1: reset held with toggling inputs, then idle with no request
        for (int k = 0; k < 6; k++) begin
            comandoIN  = k[0];
            botaoPlaca = ~k[0];
            sw         = DW'(k);
            tick();
        end
        comandoIN  = 1'b0;
        botaoPlaca = 1'b0;
        sw         = '0;
        reset      = 1'b1;
        ticks(20);

        // 2: clean press, pronto seven cycles after the press edge
        sw        = 4'hA;
        comandoIN = 1'b1;
        ticks(3);
        check("pausa_waiting", 32'(pausa), 32'd1);
        check("ledin_waiting", 32'(ledin), 32'd1);
        botaoPlaca = 1'b1;
        run_window(20, first, cnt);
        check("normal_latency", 32'(first), 32'd7);
        check("normal_count", 32'(cnt), 32'd1);
        check("normal_data", dadosLidos, 32'h0000000A);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b0;
        ticks(10);

        // 3: bouncing press, single pronto once the level is stable
        comandoIN = 1'b1;
        ticks(3);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            botaoPlaca = ((k % 4) < 2);
            tick();
            if (pronto === 1'b1) cnt++;
        end
        check("bounce_no_pronto", 32'(cnt), 32'd0);
        botaoPlaca = 1'b1;
        run_window(20, first, cnt);
        check("bounce_latency", 32'(first), 32'd7);
        check("bounce_count", 32'(cnt), 32'd1);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b0;
        ticks(10);

        // 4: button already down when the request arrives
        botaoPlaca = 1'b1;
        ticks(12);
        comandoIN = 1'b1;
        run_window(15, first, cnt);
        check("held_no_pronto", 32'(cnt), 32'd0);
        botaoPlaca = 1'b0;
        run_window(12, first, cnt);
        check("release_no_pronto", 32'(cnt), 32'd0);
        sw = 4'h3;
        ticks(3);
        botaoPlaca = 1'b1;
        run_window(20, first, cnt);
        check("repress_count", 32'(cnt), 32'd1);
        check("repress_data", dadosLidos, 32'h00000003);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b0;
        ticks(10);

        // 5: request aborted while waiting for a press
        sw        = 4'hC;
        comandoIN = 1'b1;
        ticks(4);
        comandoIN = 1'b0;
        tick();
        check("abort_pausa", 32'(pausa), 32'd0);
        run_window(10, first, cnt);
        check("abort_no_pronto", 32'(cnt), 32'd0);
        check("abort_data_kept", dadosLidos, 32'h00000003);

        // 6: asynchronous reset mid-request, then a full request
        comandoIN = 1'b1;
        ticks(4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_data", dadosLidos, 32'd0);
        check("async_rst_pronto", 32'(pronto), 32'd0);
        check("async_rst_pausa", 32'(pausa), 32'd0);
        check("async_rst_ledin", 32'(ledin), 32'd0);
        model_reset();
        ticks(3);
        #2;
        reset = 1'b1;
        sw    = 4'h5;
        ticks(3);
        botaoPlaca = 1'b1;
        run_window(20, first, cnt);
        check("post_rst_latency", 32'(first), 32'd7);
        check("post_rst_data", dadosLidos, 32'h00000005);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b0;
        ticks(10);

        // Randomised traffic: request toggles, bouncing button, moving switches
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) comandoIN = ~comandoIN;
            if (hold == 0) begin
                botaoPlaca = 1'($urandom_range(0, 1));
                hold       = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 7) == 0) sw = DW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
